// File: rtl/idu_preg_alloc.sv
// Physical-register free list with speculative/committed heads; grant is combinational (zero latency).
// Backpressure: y_idu_preg_stall when empty; flush suppresses grants. Optional checks: IDU_PREG_ALLOC_CHECK_EN.
module idu_preg_alloc (
  input  logic       clk,
  input  logic       rst_clk,
  input  logic       rtu_global_flush,
  input  logic       preg_req,
  input  logic       rtu_retire_vld,
  input  logic       rtu_release_vld,
  input  logic [5:0] rtu_release_preg,
  output logic       alloc_vld,
  output logic [5:0] alloc_preg,
  output logic       y_idu_preg_stall,
  output logic [5:0] free_cnt,
  output logic       alloc_err
);

  logic [5:0] entry [32];
  logic [5:0] spec_head;
  logic [5:0] cmt_head;
  logic [5:0] tail;
  logic [5:0] spec_nxt;
  logic [5:0] cmt_nxt;
  logic [5:0] inflight;
  logic       empty;
  logic       release_ok;
  logic       retire_ok;

  assign free_cnt = tail - spec_head;
  assign empty    = (free_cnt == 6'd0);
  assign inflight = tail - cmt_head;

  assign alloc_vld        = preg_req & ~empty & ~rtu_global_flush;
  assign alloc_preg       = alloc_vld ? entry[spec_head[4:0]] : 6'd0;
  assign y_idu_preg_stall = preg_req & empty & ~rtu_global_flush;

  // Overflowing releases and retires with nothing outstanding leave their pointer untouched.
  assign release_ok = rtu_release_vld & (inflight != 6'd32);
  assign retire_ok  = rtu_retire_vld & (cmt_head != spec_head);

  always_comb begin
    cmt_nxt  = cmt_head + {5'd0, retire_ok};
    spec_nxt = spec_head + {5'd0, alloc_vld};
    if (rtu_global_flush) begin
      spec_nxt = cmt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_clk) begin
      for (int i = 0; i < 32; i++) begin
        entry[i] <= 6'(32 + i);
      end
      spec_head <= 6'd0;
      cmt_head  <= 6'd0;
      tail      <= 6'b100000;
    end else begin
      if (release_ok) begin
        entry[tail[4:0]] <= rtu_release_preg;
        tail             <= tail + 6'd1;
      end
      cmt_head  <= cmt_nxt;
      spec_head <= spec_nxt;
    end
  end

`ifdef IDU_PREG_ALLOC_CHECK_EN
  logic err_q;
  logic proto_err;

  assign proto_err = (rtu_release_vld & ~release_ok) | (rtu_retire_vld & ~retire_ok);

  always_ff @(posedge clk) begin
    if (rst_clk) begin
      err_q <= 1'b0;
    end else if (proto_err) begin
      err_q <= 1'b1;
    end
  end

  assign alloc_err = err_q;
`else
  assign alloc_err = 1'b0;
`endif

endmodule

// File: tb/tb_idu_preg_alloc.sv
// Directed bench for idu_preg_alloc: vector table plus hand-written full-list and wrap sequences.
module tb_idu_preg_alloc;

`ifdef IDU_PREG_ALLOC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk;
  logic       rst_clk;
  logic       rtu_global_flush;
  logic       preg_req;
  logic       rtu_retire_vld;
  logic       rtu_release_vld;
  logic [5:0] rtu_release_preg;
  logic       alloc_vld;
  logic [5:0] alloc_preg;
  logic       y_idu_preg_stall;
  logic [5:0] free_cnt;
  logic       alloc_err;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic       rst;
    logic       flush;
    logic       req;
    logic       ret;
    logic       rel;
    logic [5:0] rel_preg;
    logic       chk;
    logic       exp_vld;
    logic [5:0] exp_preg;
    logic       exp_stall;
    logic [5:0] exp_cnt;
    logic       exp_err;
    string      name;
  } vec_t;

  vec_t vecs[$];

  idu_preg_alloc dut (
    .clk              (clk),
    .rst_clk          (rst_clk),
    .rtu_global_flush (rtu_global_flush),
    .preg_req         (preg_req),
    .rtu_retire_vld   (rtu_retire_vld),
    .rtu_release_vld  (rtu_release_vld),
    .rtu_release_preg (rtu_release_preg),
    .alloc_vld        (alloc_vld),
    .alloc_preg       (alloc_preg),
    .y_idu_preg_stall (y_idu_preg_stall),
    .free_cnt         (free_cnt),
    .alloc_err        (alloc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input string name, input int rst, input int flush, input int req,
                              input int ret, input int rel, input int rel_preg, input int chk,
                              input int vld, input int preg, input int stall, input int cnt,
                              input int err);
    vec_t v;
    v.name      = name;
    v.rst       = rst[0];
    v.flush     = flush[0];
    v.req       = req[0];
    v.ret       = ret[0];
    v.rel       = rel[0];
    v.rel_preg  = 6'(rel_preg);
    v.chk       = chk[0];
    v.exp_vld   = vld[0];
    v.exp_preg  = 6'(preg);
    v.exp_stall = stall[0];
    v.exp_cnt   = 6'(cnt);
    v.exp_err   = err[0];
    return v;
  endfunction

  task automatic cmp(input string name, input string field, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %0d, expected %0d", name, field, act, exp);
    end
  endtask

  // Drive after the falling edge, check the combinational outputs, then let the rising edge commit.
  task automatic apply(input vec_t v);
    rst_clk          = v.rst;
    rtu_global_flush = v.flush;
    preg_req         = v.req;
    rtu_retire_vld   = v.ret;
    rtu_release_vld  = v.rel;
    rtu_release_preg = v.rel_preg;
    #1;
    if (v.chk) begin
      cmp(v.name, "alloc_vld", int'(alloc_vld), int'(v.exp_vld));
      cmp(v.name, "alloc_preg", int'(alloc_preg), int'(v.exp_preg));
      cmp(v.name, "stall", int'(y_idu_preg_stall), int'(v.exp_stall));
      cmp(v.name, "free_cnt", int'(free_cnt), int'(v.exp_cnt));
      cmp(v.name, "alloc_err", int'(alloc_err), int'(v.exp_err));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    apply(mk("rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_clk = 1'b1;
    rtu_global_flush = 1'b0;
    preg_req = 1'b0;
    rtu_retire_vld = 1'b0;
    rtu_release_vld = 1'b0;
    rtu_release_preg = 6'd0;

    //                name       rst fl rq rt rl rp  chk vld preg st cnt err
    vecs.push_back(mk("rst",      1, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0,  0));
    vecs.push_back(mk("rst_state",0, 0, 0, 0, 0, 0,  1, 0, 0,  0, 32, 0));
    vecs.push_back(mk("grant0",   0, 0, 1, 0, 0, 0,  1, 1, 32, 0, 32, 0));
    vecs.push_back(mk("grant1",   0, 0, 1, 0, 0, 0,  1, 1, 33, 0, 31, 0));
    vecs.push_back(mk("grant2",   0, 0, 1, 0, 0, 0,  1, 1, 34, 0, 30, 0));
    vecs.push_back(mk("after3",   0, 0, 0, 0, 0, 0,  1, 0, 0,  0, 29, 0));
    vecs.push_back(mk("retire1",  0, 0, 0, 1, 0, 0,  1, 0, 0,  0, 29, 0));
    vecs.push_back(mk("flush",    0, 1, 1, 0, 0, 0,  1, 0, 0,  0, 29, 0));
    vecs.push_back(mk("post_fl",  0, 0, 1, 0, 0, 0,  1, 1, 33, 0, 31, 0));
    vecs.push_back(mk("rst",      1, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0,  0));
    vecs.push_back(mk("rf_g0",    0, 0, 1, 0, 0, 0,  1, 1, 32, 0, 32, 0));
    vecs.push_back(mk("rf_g1",    0, 0, 1, 0, 0, 0,  1, 1, 33, 0, 31, 0));
    vecs.push_back(mk("rf_both",  0, 1, 1, 1, 0, 0,  1, 0, 0,  0, 30, 0));
    vecs.push_back(mk("rf_next",  0, 0, 1, 0, 0, 0,  1, 1, 33, 0, 31, 0));
    vecs.push_back(mk("rst",      1, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0,  0));
    vecs.push_back(mk("frel_g0",  0, 0, 1, 0, 0, 0,  1, 1, 32, 0, 32, 0));
    vecs.push_back(mk("frel_ret", 0, 0, 0, 1, 0, 0,  1, 0, 0,  0, 31, 0));
    vecs.push_back(mk("frel_fr",  0, 1, 0, 0, 1, 9,  1, 0, 0,  0, 31, 0));
    vecs.push_back(mk("frel_g1",  0, 0, 1, 0, 0, 0,  1, 1, 33, 0, 32, 0));
    vecs.push_back(mk("frel_idle",0, 0, 0, 0, 0, 0,  1, 0, 0,  0, 31, 0));
    vecs.push_back(mk("rst",      1, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0,  0));
    vecs.push_back(mk("mid_g0",   0, 0, 1, 0, 0, 0,  1, 1, 32, 0, 32, 0));
    vecs.push_back(mk("mid_g1",   0, 0, 1, 0, 0, 0,  1, 1, 33, 0, 31, 0));
    vecs.push_back(mk("mid_rst",  1, 0, 1, 0, 1, 12, 0, 0, 0,  0, 0,  0));
    vecs.push_back(mk("mid_idle", 0, 0, 0, 0, 0, 0,  1, 0, 0,  0, 32, 0));
    vecs.push_back(mk("mid_g",    0, 0, 1, 0, 0, 0,  1, 1, 32, 0, 32, 0));
    vecs.push_back(mk("rst",      1, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0,  0));
    vecs.push_back(mk("ovf_rel",  0, 0, 0, 0, 1, 7,  1, 0, 0,  0, 32, 0));
    vecs.push_back(mk("ovf_err",  0, 0, 0, 0, 0, 0,  1, 0, 0,  0, 32, int'(CHK)));
    vecs.push_back(mk("ovf_stky", 0, 0, 0, 0, 0, 0,  1, 0, 0,  0, 32, int'(CHK)));
    vecs.push_back(mk("ovf_g",    0, 0, 1, 0, 0, 0,  1, 1, 32, 0, 32, int'(CHK)));

    @(negedge clk);
    foreach (vecs[i]) begin
      apply(vecs[i]);
    end

    // Drain the whole list (retiring one behind), then stall; a same-cycle release is not bypassed.
    do_reset();
    for (int k = 0; k < 32; k++) begin
      apply(mk($sformatf("full_g%0d", k), 0, 0, 1, (k > 0) ? 1 : 0, 0, 0,
               1, 1, 32 + k, 0, 32 - k, 0));
    end
    apply(mk("full_stall", 0, 0, 1, 0, 1, 5, 1, 0, 0, 1, 0, 0));
    apply(mk("full_after", 0, 0, 1, 0, 0, 0, 1, 1, 5, 0, 1, 0));

    // 40 grants with retires one cycle behind and releases two behind: pointers wrap,
    // slots 0.. get refilled with the released values 2,3,...
    do_reset();
    for (int k = 0; k < 40; k++) begin
      apply(mk($sformatf("wrap_g%0d", k), 0, 0, 1, (k >= 1) ? 1 : 0, (k >= 2) ? 1 : 0, k,
               1, 1, (k < 32) ? 32 + k : k - 30, 0, (k < 2) ? 32 - k : 30, 0));
    end
    apply(mk("wrap_idle", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 30, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
